// File: rtl/servant_gpio_ctrl.sv
// servant_gpio_ctrl: Wishbone slave sequencing the board's 4 LEDs and
// debouncing its 3 push-buttons.
//
// LEDs run in one of three modes (direct, blink, rotate) paced by a
// programmable prescaler tick. Buttons are synchronized and debounced.
// Rising edges of the debounced levels latch into write-1-to-clear events.
//
// Register map, selected by i_wb_adr[3:2]:
//   0 LED_DATA  rw [3:0]
//   1 CTRL      rw [1:0] mode (0 direct, 1 blink, 2 rotate, 3 = direct)
//   2 PERIOD    rw [PW-1:0]
//   3 BTN       r  {events[2:0], level[2:0]}, w1c events via dat[5:3]
//
// Ports:
//   i_wb_clk, i_wb_rst_n   clock, synchronous active-low reset
//   i_wb_adr/dat/we/cyc    Wishbone request
//   o_wb_rdt/o_wb_ack      registered read data, one-cycle acknowledge
//   led                    registered LED drive
//   buttons                raw asynchronous button inputs
module servant_gpio_ctrl #(
  parameter int unsigned     PW         = 24,
  parameter logic [PW-1:0]   PERIOD_RST = 24'd1000000,
  parameter int unsigned     DEB_CYCLES = 16
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [3:0]  led,
  input  logic [2:0]  buttons
);

  localparam int unsigned   DW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          ack_r;
  logic [31:0]   rdt_r;
  logic [3:0]    led_r;
  logic [3:0]    led_data_r;
  logic [1:0]    mode_r;
  logic [PW-1:0] period_r;
  logic [PW-1:0] cnt_r;
  logic          phase_r;
  logic [3:0]    pattern_r;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    level_r;
  logic [2:0]    events_r;
  logic [DW-1:0] deb_cnt_r [3];

  logic          bus_req_s;
  logic          wr_s;
  logic          wr_led_s;
  logic          wr_ctrl_s;
  logic          wr_period_s;
  logic          wr_btn_s;
  logic          tick_s;
  logic [31:0]   rd_data_s;
  logic [2:0]    level_nxt_s;
  logic [DW-1:0] deb_cnt_nxt_s [3];
  logic [2:0]    rise_s;
  logic [2:0]    clr_s;
  logic          unused_s;

  assign o_wb_ack = ack_r;
  assign o_wb_rdt = rdt_r;
  assign led      = led_r;

  // A held cyc only gets a new transfer on cycles where ack is low.
  assign bus_req_s = i_wb_cyc & ~ack_r;
  assign wr_s      = bus_req_s & i_wb_we;
  assign unused_s  = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:PW]};

  // Write strobe decode per register.
  always_comb begin
    wr_led_s    = 1'b0;
    wr_ctrl_s   = 1'b0;
    wr_period_s = 1'b0;
    wr_btn_s    = 1'b0;
    if (wr_s) begin
      case (i_wb_adr[3:2])
        2'd0:    wr_led_s    = 1'b1;
        2'd1:    wr_ctrl_s   = 1'b1;
        2'd2:    wr_period_s = 1'b1;
        2'd3:    wr_btn_s    = 1'b1;
        default: wr_led_s    = 1'b0;
      endcase
    end else begin
      wr_led_s = 1'b0;
    end
  end

  // Read data mux; unused bits read as zero.
  always_comb begin
    rd_data_s = 32'd0;
    case (i_wb_adr[3:2])
      2'd0:    rd_data_s[3:0]    = led_data_r;
      2'd1:    rd_data_s[1:0]    = mode_r;
      2'd2:    rd_data_s[PW-1:0] = period_r;
      2'd3:    rd_data_s[5:0]    = {events_r, level_r};
      default: rd_data_s         = 32'd0;
    endcase
  end

  // Bus handshake: one-cycle ack, read data captured on the request edge.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      ack_r <= 1'b0;
      rdt_r <= 32'd0;
    end else begin
      ack_r <= bus_req_s;
      if (bus_req_s) begin
        rdt_r <= rd_data_s;
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      led_data_r <= 4'd0;
      mode_r     <= 2'd0;
      period_r   <= PERIOD_RST;
    end else begin
      if (wr_led_s)    led_data_r <= i_wb_dat[3:0];
      if (wr_ctrl_s)   mode_r     <= i_wb_dat[1:0];
      if (wr_period_s) period_r   <= i_wb_dat[PW-1:0];
    end
  end

  // A PERIOD write restarts the count and swallows that cycle's tick.
  assign tick_s = ~wr_period_s & (cnt_r == period_r);

  // Prescaler 0..PERIOD; the >= also recovers if PERIOD drops below cnt.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      cnt_r <= {PW{1'b0}};
    end else if (wr_period_s || (cnt_r >= period_r)) begin
      cnt_r <= {PW{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Blink phase and rotate pattern; register writes take priority over a tick.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      phase_r   <= 1'b0;
      pattern_r <= 4'd0;
    end else if (wr_ctrl_s) begin
      phase_r   <= 1'b0;
      pattern_r <= led_data_r;
    end else begin
      if (wr_led_s && (mode_r == 2'd2)) begin
        pattern_r <= i_wb_dat[3:0];
      end else if (tick_s && (mode_r == 2'd2)) begin
        pattern_r <= {pattern_r[2:0], pattern_r[3]};
      end
      if (tick_s && (mode_r == 2'd1)) begin
        phase_r <= ~phase_r;
      end
    end
  end

  // Registered LED drive from the current mode.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      led_r <= 4'd0;
    end else begin
      case (mode_r)
        2'd1:    led_r <= phase_r ? led_data_r : 4'd0;
        2'd2:    led_r <= pattern_r;
        default: led_r <= led_data_r;
      endcase
    end
  end

  // Debounce: a level is accepted after DEB_CYCLES consecutive differing samples.
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_nxt_s[i] = deb_cnt_r[i];
      if (sync2_r[i] == level_r[i]) begin
        deb_cnt_nxt_s[i] = {DW{1'b0}};
      end else if (deb_cnt_r[i] == DEB_LAST) begin
        level_nxt_s[i]   = sync2_r[i];
        deb_cnt_nxt_s[i] = {DW{1'b0}};
      end else begin
        deb_cnt_nxt_s[i] = deb_cnt_r[i] + {{(DW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rise_s = level_nxt_s & ~level_r;
  assign clr_s  = wr_btn_s ? i_wb_dat[5:3] : 3'd0;

  // Synchronizer, debounced levels and events; a new edge beats a same-cycle clear.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      sync1_r  <= 3'd0;
      sync2_r  <= 3'd0;
      level_r  <= 3'd0;
      events_r <= 3'd0;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= {DW{1'b0}};
    end else begin
      sync1_r  <= buttons;
      sync2_r  <= sync1_r;
      level_r  <= level_nxt_s;
      events_r <= (events_r & ~clr_s) | rise_s;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= deb_cnt_nxt_s[i];
    end
  end

endmodule

// File: tb/tb_servant_gpio_ctrl.sv
// Self-checking bench for servant_gpio_ctrl: directed steps mixed with
// randomized values, LED expectations derived from tick arithmetic.
module tb_servant_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  logic [3:0]  led;
  logic [2:0]  buttons;

  int cyc_n = 0;
  int n_cmp = 0;
  int n_bad = 0;

  servant_gpio_ctrl dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_wb_adr   (adr),
    .i_wb_dat   (dat),
    .i_wb_we    (we),
    .i_wb_cyc   (cyc),
    .o_wb_rdt   (rdt),
    .o_wb_ack   (ack),
    .led        (led),
    .buttons    (buttons)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k (sampled #1 later) cyc_n == k.
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns read data and the edge number it completed on.
  task automatic wb_xfer(input logic w, input logic [1:0] idx, input logic [31:0] d,
                         output logic [31:0] r, output int e);
    logic [31:0] up;
    @(negedge clk);
    if (ack === 1'b1) @(negedge clk);
    up  = $urandom();
    adr = {up[31:4], idx, 2'b00};
    dat = d;
    we  = w;
    cyc = 1'b1;
    check("ack_before_edge", {31'd0, ack}, 32'd0);
    @(posedge clk);
    #1;
    e = cyc_n;
    check("ack_after_edge", {31'd0, ack}, 32'd1);
    r   = rdt;
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] idx, input logic [31:0] d, output int e);
    logic [31:0] r;
    wb_xfer(1'b1, idx, d, r, e);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    int e;
    wb_xfer(1'b0, idx, 32'd0, r, e);
    check(tag, r, exp);
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
    logic [7:0] x;
    x = {v, v} << k;
    return x[7:4];
  endfunction

  // Expected LED after edge t: value v loaded at edge ld, ticks every p+1 edges from w.
  function automatic logic [3:0] exp_led(input logic [1:0] m, input logic [3:0] v,
                                         input int ld, input int t, input int w, input int p);
    int n;
    logic [3:0] res;
    n = 0;
    for (int e = ld + 1; e <= t - 1; e++) begin
      if ((e > w) && (((e - w) % (p + 1)) == 0)) n++;
    end
    case (m)
      2'd1:    res = ((n % 2) == 1) ? v : 4'd0;
      2'd2:    res = rotl(v, n % 4);
      default: res = v;
    endcase
    return res;
  endfunction

  // Program PERIOD, LED_DATA, CTRL and check LED every cycle, optionally reloading.
  task automatic run_mode(input logic [1:0] m, input int p, input logic [3:0] d, input int n,
                          input logic reload, input logic [3:0] rv);
    int w;
    int e;
    int c;
    wb_wr(2'd2, p, w);
    wb_wr(2'd0, {28'd0, d}, e);
    wb_wr(2'd1, {30'd0, m}, c);
    repeat (n) begin
      @(posedge clk);
      #1;
      check($sformatf("led_m%0d_p%0d_t%0d", m, p, cyc_n - c), {28'd0, led},
            {28'd0, exp_led(m, d, c, cyc_n, w, p)});
    end
    if (reload) begin
      wb_wr(2'd0, {28'd0, rv}, e);
      repeat (n) begin
        @(posedge clk);
        #1;
        check($sformatf("led_reload_t%0d", cyc_n - e), {28'd0, led},
              {28'd0, exp_led(m, rv, e, cyc_n, w, p)});
      end
    end
    wb_rd_chk("period_readback", 2'd2, p);
    wb_rd_chk("ctrl_readback", 2'd1, {30'd0, m});
  endtask

  task automatic check_reset_regs();
    wb_rd_chk("rst_led_data", 2'd0, 32'd0);
    wb_rd_chk("rst_ctrl", 2'd1, 32'd0);
    wb_rd_chk("rst_period", 2'd2, 32'd1000000);
    wb_rd_chk("rst_btn", 2'd3, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
  endtask

  initial begin
    int e;
    logic [3:0] d;
    logic [1:0] m;
    int plen;

    rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'd0; dat = 32'd0; buttons = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_out", {28'd0, led}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdt", rdt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_regs();

    // Direct mode.
    wb_wr(2'd0, 32'h0000_000A, e);
    @(posedge clk);
    #1;
    check("direct_led_A", {28'd0, led}, 32'hA);
    wb_rd_chk("direct_readback", 2'd0, 32'hA);
    d = 4'($urandom_range(0, 15));
    wb_wr(2'd0, {28'd0, d}, e);
    @(posedge clk);
    #1;
    check("direct_led_rand", {28'd0, led}, {28'd0, d});

    // Reserved mode 3 reads back 3 and drives LED_DATA directly.
    wb_wr(2'd1, 32'hFFFF_FFFF, e);
    repeat (2) @(posedge clk);
    #1;
    check("mode3_led", {28'd0, led}, {28'd0, d});
    wb_rd_chk("mode3_readback", 2'd1, 32'd3);
    wb_wr(2'd2, 32'hFFFF_FFFF, e);
    wb_rd_chk("period_mask", 2'd2, 32'h00FF_FFFF);

    // Directed blink and rotate (with mid-run reload).
    run_mode(2'd1, 3, 4'h5, 20, 1'b0, 4'h0);
    run_mode(2'd2, 0, 4'h1, 6, 1'b1, 4'h3);

    // Randomized mode/period/data runs.
    for (int k = 0; k < 4; k++) begin
      m = 2'($urandom_range(1, 2));
      run_mode(m, $urandom_range(0, 4), 4'($urandom_range(1, 15)), 12,
               (m == 2'd2) ? 1'b1 : 1'b0, 4'($urandom_range(1, 15)));
    end

    // Short pulses (directed 10, then random 1..15) must not be accepted.
    for (int k = 0; k < 2; k++) begin
      plen = (k == 0) ? 10 : $urandom_range(1, 15);
      @(negedge clk);
      buttons = 3'b010;
      repeat (plen) @(negedge clk);
      buttons = 3'b000;
      repeat (25) @(negedge clk);
      wb_rd_chk($sformatf("pulse_%0d_ignored", plen), 2'd3, 32'd0);
    end

    // Held button: level rises exactly 18 edges after the input changes.
    @(negedge clk);
    buttons = 3'b010;
    repeat (16) @(negedge clk);
    wb_rd_chk("deb_before_accept", 2'd3, 32'h00);
    wb_rd_chk("deb_after_accept", 2'd3, 32'h12);
    repeat (20) @(negedge clk);
    wb_rd_chk("deb_held", 2'd3, 32'h12);
    wb_wr(2'd3, 32'h10, e);
    wb_rd_chk("w1c_event1", 2'd3, 32'h02);

    // Clear of events[0] on the very edge its rise lands: event wins.
    @(negedge clk);
    buttons = 3'b011;
    repeat (16) @(negedge clk);
    wb_wr(2'd3, 32'h08, e);
    wb_rd_chk("w1c_collision", 2'd3, 32'h0B);
    wb_wr(2'd3, 32'h08, e);
    wb_rd_chk("w1c_event0", 2'd3, 32'h03);
    @(negedge clk);
    buttons = 3'b000;
    repeat (25) @(negedge clk);
    wb_rd_chk("release_no_event", 2'd3, 32'h00);

    // Reset in the middle of blink with a bus cycle pending.
    run_mode(2'd1, 1, 4'hF, 6, 1'b0, 4'h0);
    for (int i = 0; (i < 4) && (led !== 4'hF); i++) begin
      @(posedge clk);
      #1;
    end
    check("blink_on_before_reset", {28'd0, led}, 32'hF);
    @(negedge clk);
    rst_n = 1'b0;
    cyc = 1'b1;
    we = 1'b0;
    adr = 32'd0;
    @(posedge clk);
    #1;
    check("midrun_rst_led", {28'd0, led}, 32'd0);
    check("midrun_rst_ack", {31'd0, ack}, 32'd0);
    check("midrun_rst_rdt", rdt, 32'd0);
    cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
